mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Pipeline boundary between the memory-access stage and write-back.
- Registers the MEM-stage result and drives the general-purpose register file write port (we/waddr/wdata).
- Holds the architectural HI/LO registers and the LL/SC link bit, with same-cycle bypass to the execute/memory stages.
- Honours the global stall vector and the exception flush.

Parameters:
- DW, 32, datapath width (GPR data, HI, LO)
- AW, 5, GPR address width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- stall  in  6  global stall vector; bit4 = MEM stalled, bit5 = WB stalled
- flush  in  1  exception flush; kills the instruction entering WB
- mem_wd  in  AW  destination GPR address from MEM
- mem_wreg  in  1  GPR write enable from MEM
- mem_wdata  in  DW  GPR write data from MEM
- mem_whilo  in  1  HI/LO write enable from MEM
- mem_hi  in  DW  HI value from MEM
- mem_lo  in  DW  LO value from MEM
- mem_llbit_we  in  1  LLbit write enable from MEM (LL/SC)
- mem_llbit_value  in  1  LLbit value from MEM
- wb_wd  out  AW  registered GPR write address; drives register-file waddr
- wb_wreg  out  1  registered GPR write enable; drives register-file we
- wb_wdata  out  DW  registered GPR write data; drives register-file wdata
- wb_whilo  out  1  registered HI/LO write enable; also forwarded to EX
- wb_hi  out  DW  registered HI write value
- wb_lo  out  DW  registered LO write value
- hi_o  out  DW  architectural HI, bypassed
- lo_o  out  DW  architectural LO, bypassed
- llbit_o  out  1  architectural LLbit, bypassed

Behaviour:
- Pipeline register (wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo, internal wb_llbit_we, wb_llbit_value), evaluated on each rising edge, first match wins:
  - rst = 1: all cleared to 0.
  - flush = 1: bubble (all cleared to 0).
  - stall[4] = 1 and stall[5] = 0: bubble (all 0). MEM is held and WB must not repeat its instruction.
  - stall[4] = 0: capture the mem_* inputs.
  - Otherwise (both stalled): hold.
- Latency: an instruction presented on mem_* appears on wb_* one cycle later when unstalled.
- wb_wreg = 1 with wb_wd = 0 is passed through unchanged; the register file ignores address 0.
- HI/LO state hi_r/lo_r:
  - rst → 0.
  - Else, if wb_whilo = 1: hi_r <= wb_hi, lo_r <= wb_lo.
  - Writing while WB is stalled rewrites the same value; this is harmless and required.
- hi_o/lo_o (combinational): wb_whilo ? wb_hi/wb_lo : hi_r/lo_r.
- LLbit state llbit_r:
  - rst → 0.
  - Else, flush → 0; flush has priority over any write.
  - Else, if wb_llbit_we: llbit_r <= wb_llbit_value.
- llbit_o (combinational):
  - flush → 0.
  - Else, wb_llbit_we ? wb_llbit_value : llbit_r.
- Reset mid-operation: every output is 0 in the cycle after the reset edge, regardless of stall or flush.
- Simultaneous flush and stall: flush wins and a bubble is inserted.
- No combinational path from mem_* to wb_*. hi_o, lo_o and llbit_o depend only on registered state and flush.

Test Plan:
- Reset: hold rst for 2 cycles with mem_wreg = 1, mem_wd = 5'd3, mem_wdata = 32'hDEADBEEF → all wb_* = 0, hi_o = lo_o = 0, llbit_o = 0.
- Passthrough: stall = 0, present mem_wreg = 1, mem_wd = 7, mem_wdata = 32'h12345678 at edge N → wb_wreg = 1, wb_wd = 7, wb_wdata = 32'h12345678 after edge N; cleared one edge after mem_wreg returns to 0.
- Stall bubble and hold:
  - stall = 6'b010000 while MEM holds wd = 9 → wb_wreg = 0 after the edge.
  - stall = 6'b110000 → previous wb_* values held unchanged.
  - Release → wd = 9 written exactly once.
- HI/LO: mem_whilo = 1, mem_hi = 32'hA, mem_lo = 32'hB → hi_o = 32'hA and lo_o = 32'hB in the same cycle wb_whilo = 1 (bypass); values persist after wb_whilo drops.
- LLbit:
  - mem_llbit_we = 1, value = 1 → llbit_o = 1 during the WB cycle and after.
  - Then flush = 1 together with a pending llbit write of 1 → llbit_o = 0 immediately, llbit_r = 0 after the edge, wb_* bubbled.
- Flush priority: flush = 1 with stall = 0 and valid mem_wreg = 1, wd = 4 → wb_wreg = 0; register-file write suppressed.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline boundary: registers the MEM result, drives the GPR write port,
// and owns the architectural HI/LO and LL/SC link bit with bypass to earlier stages.
module mem_wb_stage #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [5:0]    stall,
   input  logic          flush,
   input  logic [AW-1:0] mem_wd,
   input  logic          mem_wreg,
   input  logic [DW-1:0] mem_wdata,
   input  logic          mem_whilo,
   input  logic [DW-1:0] mem_hi,
   input  logic [DW-1:0] mem_lo,
   input  logic          mem_llbit_we,
   input  logic          mem_llbit_value,
   output logic [AW-1:0] wb_wd,
   output logic          wb_wreg,
   output logic [DW-1:0] wb_wdata,
   output logic          wb_whilo,
   output logic [DW-1:0] wb_hi,
   output logic [DW-1:0] wb_lo,
   output logic [DW-1:0] hi_o,
   output logic [DW-1:0] lo_o,
   output logic          llbit_o
);

   logic          wb_llbit_we;
   logic          wb_llbit_value;
   logic [DW-1:0] hi_r;
   logic [DW-1:0] lo_r;
   logic          llbit_r;
   logic          bubble;
   logic          unused_stall;

   assign unused_stall = ^stall[3:0];

   // MEM stalled while WB advances: WB must not re-execute MEM's held instruction.
   assign bubble = flush | (stall[4] & ~stall[5]);

   always_ff @(posedge clk) begin
      if (rst || bubble) begin
         wb_wd          <= '0;
         wb_wreg        <= 1'b0;
         wb_wdata       <= '0;
         wb_whilo       <= 1'b0;
         wb_hi          <= '0;
         wb_lo          <= '0;
         wb_llbit_we    <= 1'b0;
         wb_llbit_value <= 1'b0;
      end else if (!stall[4]) begin
         wb_wd          <= mem_wd;
         wb_wreg        <= mem_wreg;
         wb_wdata       <= mem_wdata;
         wb_whilo       <= mem_whilo;
         wb_hi          <= mem_hi;
         wb_lo          <= mem_lo;
         wb_llbit_we    <= mem_llbit_we;
         wb_llbit_value <= mem_llbit_value;
      end
   end

   // Rewriting the same value while WB is held is intentional.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_r <= '0;
         lo_r <= '0;
      end else if (wb_whilo) begin
         hi_r <= wb_hi;
         lo_r <= wb_lo;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush)
         llbit_r <= 1'b0;
      else if (wb_llbit_we)
         llbit_r <= wb_llbit_value;
   end

   assign hi_o    = wb_whilo ? wb_hi : hi_r;
   assign lo_o    = wb_whilo ? wb_lo : lo_r;
   assign llbit_o = flush ? 1'b0 : (wb_llbit_we ? wb_llbit_value : llbit_r);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus random traffic against a
// slot/architectural-state model of the MEM/WB boundary.
module tb_mem_wb_stage;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int VW = AW + 1 + DW + 1 + 4*DW + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [5:0]    stall;
   logic          flush;
   logic [AW-1:0] mem_wd;
   logic          mem_wreg;
   logic [DW-1:0] mem_wdata;
   logic          mem_whilo;
   logic [DW-1:0] mem_hi, mem_lo;
   logic          mem_llbit_we, mem_llbit_value;
   logic [AW-1:0] wb_wd;
   logic          wb_wreg;
   logic [DW-1:0] wb_wdata;
   logic          wb_whilo;
   logic [DW-1:0] wb_hi, wb_lo, hi_o, lo_o;
   logic          llbit_o;

   int errors = 0;
   int checks = 0;

   mem_wb_stage #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
      .mem_llbit_we(mem_llbit_we), .mem_llbit_value(mem_llbit_value),
      .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
      .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
      .hi_o(hi_o), .lo_o(lo_o), .llbit_o(llbit_o)
   );

   always #5 clk = ~clk;

   // Model: the instruction occupying WB, plus architectural HI/LO/LLbit.
   typedef struct packed {
      logic [AW-1:0] wd;
      logic          wreg;
      logic [DW-1:0] wdata;
      logic          whilo;
      logic [DW-1:0] hi;
      logic [DW-1:0] lo;
      logic          llwe;
      logic          llv;
   } slot_t;

   slot_t         sl = '0;
   logic [DW-1:0] m_hi = '0, m_lo = '0;
   logic          m_ll = 1'b0;

   function automatic logic [VW-1:0] exp_vec();
      logic [DW-1:0] h, l;
      logic ll;
      h  = sl.whilo ? sl.hi : m_hi;
      l  = sl.whilo ? sl.lo : m_lo;
      ll = flush ? 1'b0 : (sl.llwe ? sl.llv : m_ll);
      return {sl.wd, sl.wreg, sl.wdata, sl.whilo, sl.hi, sl.lo, h, l, ll};
   endfunction

   function automatic logic [VW-1:0] obs_vec();
      return {wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo, hi_o, lo_o, llbit_o};
   endfunction

   // Advance one clock: the model consumes the inputs as they stand before the edge.
   task automatic step();
      slot_t ns;
      logic [DW-1:0] nh, nl;
      logic nll;
      ns = sl; nh = m_hi; nl = m_lo; nll = m_ll;
      if (rst) begin
         ns = '0; nh = '0; nl = '0; nll = 1'b0;
      end else begin
         if (sl.whilo) begin nh = sl.hi; nl = sl.lo; end
         if (flush) nll = 1'b0;
         else if (sl.llwe) nll = sl.llv;
         if (flush || (stall[4] && !stall[5])) ns = '0;
         else if (!stall[4])
            ns = '{mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
                   mem_llbit_we, mem_llbit_value};
      end
      @(posedge clk);
      #1;
      sl = ns; m_hi = nh; m_lo = nl; m_ll = nll;
   endtask

   task automatic clear_in();
      stall = '0; flush = 1'b0;
      mem_wd = '0; mem_wreg = 1'b0; mem_wdata = '0;
      mem_whilo = 1'b0; mem_hi = '0; mem_lo = '0;
      mem_llbit_we = 1'b0; mem_llbit_value = 1'b0;
   endtask

   task automatic test_reset();
      clear_in();
      rst = 1'b1;
      mem_wreg = 1'b1; mem_wd = 5'd3; mem_wdata = 32'hDEADBEEF;
      step(); step();
      checks++;
      if (obs_vec() !== '0) begin
         errors++; $display("FAIL reset_zero: got %h want 0", obs_vec());
      end
      rst = 1'b0;
      clear_in();
   endtask

   task automatic test_passthrough();
      mem_wreg = 1'b1; mem_wd = 5'd7; mem_wdata = 32'h12345678;
      step();
      checks++;
      if ({wb_wreg, wb_wd, wb_wdata} !== {1'b1, 5'd7, 32'h12345678}) begin
         errors++; $display("FAIL passthrough: got %b/%0d/%h want 1/7/12345678", wb_wreg, wb_wd, wb_wdata);
      end
      mem_wreg = 1'b0;
      step();
      checks++;
      if (wb_wreg !== 1'b0) begin
         errors++; $display("FAIL passthrough_clear: got %b want 0", wb_wreg);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL passthrough_model: got %h want %h", obs_vec(), exp_vec());
      end
      clear_in();
   endtask

   task automatic test_stall();
      int writes;
      mem_wreg = 1'b1; mem_wd = 5'd9; mem_wdata = 32'h0000_0909;
      stall = 6'b010000;
      step();
      checks++;
      if (wb_wreg !== 1'b0) begin
         errors++; $display("FAIL stall_bubble: got %b want 0", wb_wreg);
      end
      stall = 6'b110000;
      step();
      checks++;
      if (obs_vec() !== exp_vec() || wb_wreg !== 1'b0) begin
         errors++; $display("FAIL stall_hold_bubble: got %h want %h", obs_vec(), exp_vec());
      end
      stall = 6'b000000;
      writes = 0;
      step();
      if (wb_wreg && wb_wd == 5'd9) writes++;
      mem_wreg = 1'b0; mem_wd = '0;
      step();
      if (wb_wreg && wb_wd == 5'd9) writes++;
      checks++;
      if (writes != 1) begin
         errors++; $display("FAIL stall_release_once: got %0d writes want 1", writes);
      end
      // Hold a live instruction with both stages stalled.
      mem_wreg = 1'b1; mem_wd = 5'd12; mem_wdata = 32'hCAFE0012;
      step();
      stall = 6'b110000; mem_wd = 5'd13; mem_wdata = 32'h0;
      step(); step();
      checks++;
      if ({wb_wreg, wb_wd, wb_wdata} !== {1'b1, 5'd12, 32'hCAFE0012}) begin
         errors++; $display("FAIL stall_hold_live: got %b/%0d/%h want 1/12/cafe0012", wb_wreg, wb_wd, wb_wdata);
      end
      clear_in();
      step();
   endtask

   task automatic test_hilo();
      mem_whilo = 1'b1; mem_hi = 32'hA; mem_lo = 32'hB;
      step();
      checks++;
      if ({wb_whilo, hi_o, lo_o} !== {1'b1, 32'hA, 32'hB}) begin
         errors++; $display("FAIL hilo_bypass: got %b/%h/%h want 1/a/b", wb_whilo, hi_o, lo_o);
      end
      clear_in();
      step();
      checks++;
      if ({wb_whilo, hi_o, lo_o} !== {1'b0, 32'hA, 32'hB}) begin
         errors++; $display("FAIL hilo_persist: got %b/%h/%h want 0/a/b", wb_whilo, hi_o, lo_o);
      end
   endtask

   task automatic test_llbit();
      mem_llbit_we = 1'b1; mem_llbit_value = 1'b1;
      step();
      checks++;
      if (llbit_o !== 1'b1) begin
         errors++; $display("FAIL llbit_bypass: got %b want 1", llbit_o);
      end
      clear_in();
      step();
      checks++;
      if (llbit_o !== 1'b1) begin
         errors++; $display("FAIL llbit_persist: got %b want 1", llbit_o);
      end
      mem_llbit_we = 1'b1; mem_llbit_value = 1'b1; mem_wreg = 1'b1; mem_wd = 5'd2;
      step();
      flush = 1'b1;
      #1;
      checks++;
      if (llbit_o !== 1'b0) begin
         errors++; $display("FAIL llbit_flush_comb: got %b want 0", llbit_o);
      end
      step();
      clear_in();
      #1;
      checks++;
      if ({llbit_o, wb_wreg, wb_llbit_probe()} !== 3'b000) begin
         errors++; $display("FAIL llbit_flush_reg: got llbit=%b wreg=%b want 0/0", llbit_o, wb_wreg);
      end
   endtask

   function automatic logic wb_llbit_probe();
      return obs_vec() != '0 && (wb_wreg | wb_whilo);
   endfunction

   task automatic test_flush();
      mem_wreg = 1'b1; mem_wd = 5'd4; mem_wdata = 32'h44;
      flush = 1'b1;
      step();
      checks++;
      if (wb_wreg !== 1'b0 || wb_wd !== 5'd0) begin
         errors++; $display("FAIL flush_kill: got %b/%0d want 0/0", wb_wreg, wb_wd);
      end
      flush = 1'b0;
      step();
      stall = 6'b110000; flush = 1'b1;
      step();
      checks++;
      if (wb_wreg !== 1'b0) begin
         errors++; $display("FAIL flush_over_stall: got %b want 0", wb_wreg);
      end
      clear_in();
      step();
   endtask

   task automatic test_reset_mid();
      mem_wreg = 1'b1; mem_wd = 5'd21; mem_whilo = 1'b1; mem_hi = 32'h1111; mem_lo = 32'h2222;
      mem_llbit_we = 1'b1; mem_llbit_value = 1'b1;
      step(); step();
      rst = 1'b1; stall = 6'b110000;
      step();
      checks++;
      if (obs_vec() !== '0) begin
         errors++; $display("FAIL reset_mid: got %h want 0", obs_vec());
      end
      rst = 1'b0;
      clear_in();
   endtask

   task automatic test_random();
      logic [5:0] st;
      for (int i = 0; i < 400; i++) begin
         rst             = ($urandom_range(0, 49) == 0);
         flush           = ($urandom_range(0, 9) == 0);
         st              = 6'($urandom);
         stall           = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), st[3:0]};
         mem_wd          = AW'($urandom);
         mem_wreg        = 1'($urandom);
         mem_wdata       = $urandom;
         mem_whilo       = 1'($urandom);
         mem_hi          = $urandom;
         mem_lo          = $urandom;
         mem_llbit_we    = 1'($urandom);
         mem_llbit_value = 1'($urandom);
         step();
         flush = ($urandom_range(0, 7) == 0);
         #1;
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL random[%0d]: got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      rst = 1'b0;
      clear_in();
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_stall();
      test_hilo();
      test_llbit();
      test_flush();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
